mole_round_controller: RTL and testbench
========================================

# mole_round_controller

Sequences one round of the whack-a-mole game. Picks a pseudo-random hole, lights its mole for a fixed window, and judges the debounced single-cycle button pulses from the per-hole button detectors. Keeps score and miss counts, and signals end of round. Sits between the button-detector bank (inputs) and the LED and display drivers (outputs).

## Interface
- NUM_HOLES, 4: number of holes/buttons; must be a power of two, 2..16.
- MOLE_CYCLES, 50_000_000: clock cycles a mole stays lit if not hit; ≥2.
- GAP_CYCLES, 12_500_000: dark cycles between moles; ≥1.
- MOLES_PER_ROUND, 16: moles shown per round; ≥1.
- SCORE_W, 5: width of score and misses; must satisfy 2^SCORE_W > MOLES_PER_ROUND.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- hit  in  NUM_HOLES  one-cycle press pulses, one bit per hole; several bits may be set together.
- mole  out  NUM_HOLES  one-hot lit hole; all zero when no mole is shown.
- score  out  SCORE_W  correct hits this round.
- misses  out  SCORE_W  timeouts plus wrong-hole presses; saturates at all-ones.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of round.

## Operation
- **States:** IDLE, PICK, SHOW, GAP, DONE.
- **Reset:** rst low forces everything immediately, without waiting for clk.
  - State goes to IDLE.
  - mole, score, misses, busy and done go to 0.
  - The LFSR loads 8'hA5.
  - The previous-hole register loads 0.
  - The mole counter loads 0.
- **LFSR:** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every clock in every state, reset excepted.
- **IDLE:**
  - start=1 clears score, misses and the mole counter, then moves to PICK.
  - score and misses hold their last values while waiting.
- **PICK (one cycle):**
  - Candidate = LFSR[log2(NUM_HOLES)-1:0].
  - If the candidate equals the previous hole, use (candidate+1) mod NUM_HOLES.
  - Store the result as the current and previous hole, load the window timer, then go to SHOW.
- **SHOW:** mole = one-hot of the current hole. Each cycle, checks are made in this priority order:
  1. If hit has the current-hole bit set, it is a hit: score+1, go to GAP. Any other bits set in the same cycle are ignored.
  2. If hit is nonzero but misses the current hole, it is a wrong press: misses+1 (saturating), at most one per cycle. Stay in SHOW; the timer keeps running.
  3. If the timer expires (the MOLE_CYCLES-th SHOW cycle) with no hit, it is a timeout: misses+1, go to GAP.
  - A hit in the expiry cycle counts as a hit, not a timeout.
- **GAP:**
  - mole=0; hit is ignored.
  - After GAP_CYCLES cycles the mole counter increments.
  - If the counter reaches MOLES_PER_ROUND, go to DONE; otherwise go to PICK.
- **DONE (one cycle):** done=1, then IDLE.
- **start while busy:** ignored; it has no effect on the running round.

## Timing
- **Start:** start is sampled high in IDLE at edge 0. Then:
  - PICK occupies cycle 1.
  - SHOW begins in cycle 2; mole is registered and nonzero from cycle 2.
  - busy is high from cycle 1.
- **Hit in SHOW cycle k:** mole=0 and score updated in cycle k+1, which is the first GAP cycle.
- **No-hit mole:** mole is lit for exactly MOLE_CYCLES cycles, followed by GAP_CYCLES dark cycles.
- **Per-mole period without hits:** 1+MOLE_CYCLES+GAP_CYCLES cycles.
- **done:** asserted the cycle after the last GAP cycle.
- **busy:** falls together with the move to IDLE, one cycle after done.
- **Outputs:** all registered; no combinational path from hit or start to any output.

## Test plan
Benches use NUM_HOLES=4, MOLE_CYCLES=8, GAP_CYCLES=2, MOLES_PER_ROUND=4 and SCORE_W=5.
- **No presses, full round:** start pulse → 4 moles, each lit for 8 cycles. Consecutive holes always differ. done pulses in cycle 45 after accept. Then score=0, misses=4, busy=0.
- **Correct press 3 cycles into every SHOW:** mole clears the next cycle. Final score=4, misses=0. done arrives earlier than in the no-press run, by 4×5 cycles.
- **Wrong press then correct press in each mole:** one cycle with a wrong bit, then the correct bit → score=4, misses=4. Mole stays lit through the wrong press.
- **Simultaneous and edge-case presses:**
  - hit=4'b1111 during SHOW → score+1 only, misses unchanged.
  - Correct press in the 8th SHOW cycle → counted as a hit, misses unchanged.
- **Start during a round:** start held high through the round → no restart. After done, the next round begins from IDLE and score/misses clear at acceptance.
- **Reset mid-round:** rst low in the 4th SHOW cycle → mole, score, misses, busy and done read 0 before the next clk edge. LFSR reseeds, so the post-reset pick sequence matches a fresh run.

Source files
------------

// File: rtl/mole_round_controller_if.sv
// Bundles the game-side signals of the round controller: start/press inputs from
// the button-detector bank and the mole, score and status outputs toward the
// LED and display drivers.
interface mole_round_controller_if #(
    parameter int NUM_HOLES = 4,
    parameter int SCORE_W   = 5
);
    logic                 start;
    logic [NUM_HOLES-1:0] hit;
    logic [NUM_HOLES-1:0] mole;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic                 busy;
    logic                 done;

    // Drives start and presses, observes the round outputs.
    modport master (
        output start, hit,
        input  mole, score, misses, busy, done
    );

    // The round controller itself.
    modport slave (
        input  start, hit,
        output mole, score, misses, busy, done
    );
endinterface

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer. Picks a pseudo-random hole that never repeats
// the previous one, lights it for a fixed window, judges button pulses and
// keeps score/miss counts. All outputs come straight from registers.
module mole_round_controller #(
    parameter int NUM_HOLES       = 4,
    parameter int MOLE_CYCLES     = 50_000_000,
    parameter int GAP_CYCLES      = 12_500_000,
    parameter int MOLES_PER_ROUND = 16,
    parameter int SCORE_W         = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    mole_round_controller_if.slave  bus
);
    localparam int HOLE_W  = $clog2(NUM_HOLES);
    localparam int CNT_W   = $clog2(MOLES_PER_ROUND + 1);
    localparam int MAX_CYC = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t               r_state;
    logic [7:0]           r_lfsr;
    logic [HOLE_W-1:0]    r_hole;      // current hole, doubles as "previous hole" for the next pick
    logic [TMR_W-1:0]     r_timer;     // counts down the SHOW window and the GAP
    logic [CNT_W-1:0]     r_mole_cnt;
    logic [NUM_HOLES-1:0] r_mole;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_misses;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_lfsr_fb;
    logic [HOLE_W-1:0]    w_candidate;
    logic [HOLE_W-1:0]    w_pick;
    logic [NUM_HOLES-1:0] w_pick_onehot;
    logic [NUM_HOLES-1:0] w_hit_sel;
    logic                 w_hit_cur;
    logic                 w_any_press;
    logic [SCORE_W-1:0]   w_misses_inc;
    logic [CNT_W-1:0]     w_cnt_next;

    // x^8+x^6+x^5+x^4+1 Fibonacci feedback
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Bump the candidate by one when it would repeat the last hole; the
    // power-of-two hole count makes the wrap free.
    assign w_candidate  = r_lfsr[HOLE_W-1:0];
    assign w_pick       = (w_candidate == r_hole) ? (w_candidate + HOLE_W'(1)) : w_candidate;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
            assign w_pick_onehot[gi] = (w_pick == HOLE_W'(gi));
            assign w_hit_sel[gi]     = bus.hit[gi] & (r_hole == HOLE_W'(gi));
        end
    endgenerate

    assign w_hit_cur    = |w_hit_sel;
    assign w_any_press  = |bus.hit;
    assign w_misses_inc = (&r_misses) ? r_misses : (r_misses + SCORE_W'(1));
    assign w_cnt_next   = r_mole_cnt + CNT_W'(1);

    // Round state machine with registered outputs; LFSR free-runs in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= 8'hA5;
            r_hole     <= '0;
            r_timer    <= '0;
            r_mole_cnt <= '0;
            r_mole     <= '0;
            r_score    <= '0;
            r_misses   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_score    <= '0;
                        r_misses   <= '0;
                        r_mole_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    r_hole  <= w_pick;
                    r_mole  <= w_pick_onehot;
                    r_timer <= TMR_W'(MOLE_CYCLES - 1);
                    r_state <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_hit_cur) begin
                        // Correct hole wins even in the expiry cycle; extra bits are ignored
                        r_score <= r_score + SCORE_W'(1);
                        r_mole  <= '0;
                        r_timer <= TMR_W'(GAP_CYCLES - 1);
                        r_state <= ST_GAP;
                    end else if (r_timer == '0) begin
                        // Window over; a stray press in this same cycle folds into the one miss
                        r_misses <= w_misses_inc;
                        r_mole   <= '0;
                        r_timer  <= TMR_W'(GAP_CYCLES - 1);
                        r_state  <= ST_GAP;
                    end else begin
                        if (w_any_press) begin
                            r_misses <= w_misses_inc;
                        end
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_timer == '0) begin
                        r_mole_cnt <= w_cnt_next;
                        if (w_cnt_next == CNT_W'(MOLES_PER_ROUND)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_PICK;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mole   = r_mole;
    assign bus.score  = r_score;
    assign bus.misses = r_misses;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller: rounds are played as transactions, each
// mole's outcome predicted from the game rules (pick from LFSR, first correct
// press wins, other presses and timeouts add a saturating miss).
module tb_mole_round_controller;
    localparam int NH   = 4;
    localparam int MC   = 8;
    localparam int GC   = 2;
    localparam int MPR  = 4;
    localparam int SW   = 5;
    localparam int MMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mole_round_controller_if #(.NUM_HOLES(NH), .SCORE_W(SW)) bus ();

    mole_round_controller #(
        .NUM_HOLES      (NH),
        .MOLE_CYCLES    (MC),
        .GAP_CYCLES     (GC),
        .MOLES_PER_ROUND(MPR),
        .SCORE_W        (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference LFSR sequence: x^8+x^6+x^5+x^4+1, seeded by reset
    logic [7:0] lfsr_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    end

    int exp_score;
    int exp_misses;
    int prev_hole;
    int prev_obs;
    int round_holes [MPR];
    int first_holes [MPR];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Press pattern for SHOW cycle k of the mole at hole cand
    function automatic logic [NH-1:0] stim(input int mode, input int k, input int cand);
        logic [NH-1:0] oh;
        logic [NH-1:0] wrong;
        int r;
        oh    = NH'(1) << cand;
        wrong = NH'($urandom_range(1, (1 << NH) - 1)) & ~oh;
        if (wrong == '0) wrong = NH'(1) << ((cand + 1) % NH);
        r = int'($urandom_range(0, 9));
        case (mode)
            1:       stim = (k == 3) ? oh : '0;
            2:       stim = (k == 1) ? wrong : ((k == 2) ? oh : '0);
            3:       stim = (k == 2) ? {NH{1'b1}} : '0;
            4:       stim = (k == MC) ? oh : '0;
            5:       stim = (k < MC) ? wrong : '0;
            6: begin
                if (k == MC)    stim = (r < 3) ? oh : '0;
                else if (r < 2) stim = oh | wrong;
                else if (r < 5) stim = wrong;
                else            stim = '0;
            end
            default: stim = '0;
        endcase
    endfunction

    task automatic do_reset();
        bus.start = 1'b0;
        bus.hit   = '0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        prev_hole  = 0;
        prev_obs   = 1;
        exp_score  = 0;
        exp_misses = 0;
        repeat (3) @(negedge clk);
    endtask

    // One full round from IDLE back to IDLE; called on a negedge with DUT idle
    task automatic run_round(input int mode, input int exp_done_cyc, input bit hold_start);
        int cyc;
        int cand;
        int k;
        bit got_hit;
        logic [NH-1:0] h;
        bus.start = 1'b1;
        @(negedge clk);
        cyc        = 1;
        exp_score  = 0;
        exp_misses = 0;
        check("busy_pick", int'(bus.busy), 1);
        check("score_clr", int'(bus.score), 0);
        check("misses_clr", int'(bus.misses), 0);
        if (!hold_start) bus.start = 1'b0;
        for (int m = 0; m < MPR; m++) begin
            check("mole_dark_pick", int'(bus.mole), 0);
            cand = int'(lfsr_m[1:0]);
            if (cand == prev_hole) cand = (cand + 1) % NH;
            prev_hole      = cand;
            round_holes[m] = cand;
            @(negedge clk);
            cyc++;
            check("hole_differs", int'(int'(bus.mole) != prev_obs), 1);
            prev_obs = int'(bus.mole);
            got_hit  = 1'b0;
            k        = 1;
            while (!got_hit && k <= MC) begin
                check("mole_lit", int'(bus.mole), 1 << cand);
                h       = stim(mode, k, cand);
                bus.hit = h;
                if (h[cand]) begin
                    got_hit = 1'b1;
                    exp_score++;
                end else if (h != '0 || k == MC) begin
                    exp_misses = (exp_misses < MMAX) ? exp_misses + 1 : MMAX;
                end
                @(negedge clk);
                cyc++;
                k++;
                check("score", int'(bus.score), exp_score);
                check("misses", int'(bus.misses), exp_misses);
            end
            for (int g = 0; g < GC; g++) begin
                check("mole_dark_gap", int'(bus.mole), 0);
                check("busy_gap", int'(bus.busy), 1);
                bus.hit = NH'($urandom_range(0, (1 << NH) - 1));
                @(negedge clk);
                cyc++;
            end
            bus.hit = '0;
            if (m == MPR - 1) begin
                check("done_pulse", int'(bus.done), 1);
                check("busy_done", int'(bus.busy), 1);
                if (exp_done_cyc >= 0) check("done_cycle", cyc, exp_done_cyc);
            end else begin
                check("done_low", int'(bus.done), 0);
            end
        end
        @(negedge clk);
        check("busy_idle", int'(bus.busy), 0);
        check("done_idle", int'(bus.done), 0);
        check("score_hold", int'(bus.score), exp_score);
        check("misses_hold", int'(bus.misses), exp_misses);
        $display("[TB] round mode=%0d score=%0d misses=%0d holes=%0d,%0d,%0d,%0d",
                 mode, bus.score, bus.misses,
                 round_holes[0], round_holes[1], round_holes[2], round_holes[3]);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.hit   = '0;
        do_reset();
        check("rst_mole", int'(bus.mole), 0);
        check("rst_score", int'(bus.score), 0);
        check("rst_misses", int'(bus.misses), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);

        run_round(0, 45, 1'b0);
        for (int i = 0; i < MPR; i++) first_holes[i] = round_holes[i];
        run_round(1, 25, 1'b0);
        run_round(2, 21, 1'b0);
        run_round(3, 21, 1'b0);
        run_round(4, 45, 1'b0);
        run_round(0, 45, 1'b1);
        run_round(6, -1, 1'b0);
        run_round(5, 45, 1'b0);
        for (int i = 0; i < 3; i++) run_round(6, -1, 1'b0);

        // Reset in the 4th SHOW cycle of a round
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_mole", int'(bus.mole), 0);
        check("async_score", int'(bus.score), 0);
        check("async_misses", int'(bus.misses), 0);
        check("async_busy", int'(bus.busy), 0);
        check("async_done", int'(bus.done), 0);
        do_reset();
        run_round(0, 45, 1'b0);
        for (int i = 0; i < MPR; i++) check("reseed_hole", round_holes[i], first_holes[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
